// File: rtl/lisa_debug_uart.sv
// Debug serial port for the LISA core: programmable baud tick generator,
// 8N1 transmitter with one-byte holding buffer and 8N1 receiver with data register.
module lisa_debug_uart (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_set,
  input  logic [6:0] baud_div,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_d,
  output logic       baud_ref,
  input  logic       tx_wr,
  input  logic [7:0] tx_d,
  output logic       tx_buf_empty,
  output logic       txd,
  input  logic       rxd,
  input  logic       rx_rd,
  output logic [7:0] rx_d,
  output logic       rx_avail
);

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [6:0] div_reg, div_act, baud_cnt, baud_cnt_nxt;
  logic       unused_cfg;

  tx_state_t  tx_state, tx_state_nxt;
  logic       buf_full, buf_full_nxt;
  logic [3:0] tx_tc, tx_tc_nxt, tx_bit, tx_bit_nxt;
  logic       txd_nxt, tx_load, tx_shift;
  logic [7:0] tx_buf, tx_sh;

  rx_state_t  rx_state, rx_state_nxt;
  logic       rx_s1, rx_s2, rx_armed, rx_armed_nxt;
  logic [3:0] rx_tc, rx_tc_nxt;
  logic [2:0] rx_bit, rx_bit_nxt;
  logic       rx_shift, rx_done;
  logic [7:0] rx_sh;

  assign unused_cfg   = cfg_d[7];
  assign div_act      = baud_set ? baud_div : div_reg;
  // Tick is registered from the reload condition so N=0 ticks every clock.
  assign baud_cnt_nxt = (baud_cnt == 7'd0) ? div_act : baud_cnt - 7'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg  <= '0;
      baud_cnt <= '0;
      baud_ref <= 1'b0;
    end else begin
      if (cfg_wr) div_reg <= cfg_d[6:0];
      baud_cnt <= baud_cnt_nxt;
      baud_ref <= (baud_cnt_nxt == 7'd0);
    end
  end

  assign tx_buf_empty = ~buf_full;

  always_comb begin
    tx_state_nxt = tx_state;
    tx_tc_nxt    = tx_tc;
    tx_bit_nxt   = tx_bit;
    txd_nxt      = txd;
    buf_full_nxt = buf_full;
    tx_load      = 1'b0;
    tx_shift     = 1'b0;
    if (tx_wr && !buf_full) buf_full_nxt = 1'b1;
    if (baud_ref) begin
      if (tx_state == TX_BUSY && !(tx_tc == 4'd15 && tx_bit == 4'd9)) begin
        tx_tc_nxt = tx_tc + 4'd1;
        if (tx_tc == 4'd15) begin
          tx_bit_nxt = tx_bit + 4'd1;
          if (tx_bit < 4'd8) begin
            txd_nxt  = tx_sh[0];
            tx_shift = 1'b1;
          end else begin
            txd_nxt = 1'b1;
          end
        end
      end else if (buf_full) begin
        // Also taken on the closing tick of a stop bit: frames run back to back.
        tx_load      = 1'b1;
        tx_state_nxt = TX_BUSY;
        tx_tc_nxt    = '0;
        tx_bit_nxt   = '0;
        txd_nxt      = 1'b0;
        buf_full_nxt = 1'b0;
      end else begin
        tx_state_nxt = TX_IDLE;
        txd_nxt      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      buf_full <= 1'b0;
      tx_tc    <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      buf_full <= buf_full_nxt;
      tx_tc    <= tx_tc_nxt;
      tx_bit   <= tx_bit_nxt;
      txd      <= txd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_wr && !buf_full) tx_buf <= tx_d;
    if (tx_load)       tx_sh <= tx_buf;
    else if (tx_shift) tx_sh <= {1'b0, tx_sh[7:1]};
  end

  // A start is only accepted once a high level has been sampled in idle.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_tc_nxt    = rx_tc;
    rx_bit_nxt   = rx_bit;
    rx_armed_nxt = rx_armed;
    rx_shift     = 1'b0;
    rx_done      = 1'b0;
    if (baud_ref) begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_s2) begin
            rx_armed_nxt = 1'b1;
          end else if (rx_armed) begin
            rx_state_nxt = RX_START;
            rx_tc_nxt    = '0;
          end
        end
        RX_START: begin
          rx_tc_nxt = rx_tc + 4'd1;
          if (rx_tc == 4'd7) begin
            rx_tc_nxt    = '0;
            rx_bit_nxt   = '0;
            rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_tc_nxt = rx_tc + 4'd1;
          if (rx_tc == 4'd15) begin
            rx_shift   = 1'b1;
            rx_bit_nxt = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
          end
        end
        RX_STOP: begin
          rx_tc_nxt = rx_tc + 4'd1;
          if (rx_tc == 4'd15) begin
            rx_done      = rx_s2;
            rx_armed_nxt = 1'b0;
            rx_state_nxt = RX_IDLE;
          end
        end
        default: rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_armed <= 1'b0;
      rx_tc    <= '0;
      rx_bit   <= '0;
      rx_d     <= 8'h00;
      rx_avail <= 1'b0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_nxt;
      rx_armed <= rx_armed_nxt;
      rx_tc    <= rx_tc_nxt;
      rx_bit   <= rx_bit_nxt;
      if (rx_done) begin
        rx_d     <= rx_sh;
        rx_avail <= 1'b1;
      end else if (rx_rd) begin
        rx_avail <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_shift) rx_sh <= {rx_s2, rx_sh[7:1]};
  end

endmodule

// File: tb/tb_lisa_debug_uart.sv
// Directed bench for lisa_debug_uart: baud generator, TX framing, loopback RX,
// framing error, glitch rejection, overrun and asynchronous reset.
module tb_lisa_debug_uart;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_set = 1'b1;
  logic [6:0] baud_div = 7'd3;
  logic       cfg_wr = 1'b0;
  logic [7:0] cfg_d = 8'h00;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_d = 8'h00;
  logic       rx_rd = 1'b0;
  logic       loop = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       baud_ref, tx_buf_empty, txd, rx_avail;
  logic [7:0] rx_d;
  wire        rxd;
  int         n_assert = 0;
  int         n_fail = 0;
  int         n, lows;

  assign rxd = loop ? txd : rxd_drv;
  always #5 clk = ~clk;

  lisa_debug_uart dut (
    .clk(clk), .rst(rst), .baud_set(baud_set), .baud_div(baud_div),
    .cfg_wr(cfg_wr), .cfg_d(cfg_d), .baud_ref(baud_ref),
    .tx_wr(tx_wr), .tx_d(tx_d), .tx_buf_empty(tx_buf_empty), .txd(txd),
    .rxd(rxd), .rx_rd(rx_rd), .rx_d(rx_d), .rx_avail(rx_avail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int c);
    repeat (c) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ref(output int c);
    c = 0;
    do begin step(1); c++; end while (!baud_ref && c < 300);
  endtask

  task automatic wait_txd_low(output int c);
    c = 0;
    while (txd !== 1'b0 && c < 1000) begin step(1); c++; end
  endtask

  task automatic write_tx(input logic [7:0] b);
    tx_d = b; tx_wr = 1'b1; step(1); tx_wr = 1'b0;
  endtask

  task automatic check_frame(input logic [7:0] b, input bit inject,
                             input logic [7:0] d2, input logic [7:0] d3);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      chk("frame_bit_head", txd, f[k]);
      if (inject && k == 0) begin
        write_tx(d2);
        chk("buf_full_after_2nd", tx_buf_empty, 1'b0);
        write_tx(d3);
        step(61);
      end else begin
        step(63);
      end
      chk("frame_bit_tail", txd, f[k]);
      step(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int k = 0; k < 10; k++) begin rxd_drv = f[k]; step(64); end
    rxd_drv = 1'b1;
    step(64);
  endtask

  initial begin
    step(3);
    chk("rst_baud_ref", baud_ref, 1'b0);
    chk("rst_txd", txd, 1'b1);
    chk("rst_buf_empty", tx_buf_empty, 1'b1);
    chk("rst_rx_d", rx_d, 8'h00);
    chk("rst_rx_avail", rx_avail, 1'b0);
    rst = 1'b0;

    // Baud generator, external divisor 3
    wait_ref(n);
    chk("first_ref_latency", n, 4);
    wait_ref(n);
    chk("ref_period_div3", n, 4);
    step(1);
    chk("ref_width", baud_ref, 1'b0);

    // Internal divisor register, bit 7 of cfg_d ignored
    cfg_d = 8'h89; cfg_wr = 1'b1; step(1); cfg_wr = 1'b0; baud_set = 1'b0;
    wait_ref(n); wait_ref(n); wait_ref(n);
    chk("ref_period_div9", n, 10);
    baud_set = 1'b1;
    wait_ref(n); wait_ref(n); wait_ref(n);
    chk("ref_period_back3", n, 4);

    // Single byte 0x55
    step(5);
    write_tx(8'h55);
    chk("buf_full_after_wr", tx_buf_empty, 1'b0);
    wait_txd_low(n);
    chk("tx_start_latency_ok", (n >= 1 && n <= 4), 1'b1);
    chk("buf_empty_at_start", tx_buf_empty, 1'b1);
    check_frame(8'h55, 1'b0, 8'h00, 8'h00);
    chk("idle_after_55", txd, 1'b1);

    // Back-to-back frames, third write dropped
    step(10);
    write_tx(8'hA5);
    wait_txd_low(n);
    chk("b2b_start_seen", (n < 1000), 1'b1);
    check_frame(8'hA5, 1'b1, 8'h3C, 8'hFF);
    check_frame(8'h3C, 1'b0, 8'h00, 8'h00);
    lows = 0;
    for (int i = 0; i < 700; i++) begin step(1); if (txd == 1'b0) lows++; end
    chk("no_third_frame", lows, 0);
    chk("buf_empty_after_b2b", tx_buf_empty, 1'b1);

    // Loopback receive
    loop = 1'b1;
    step(5);
    write_tx(8'hA5);
    wait_txd_low(n);
    n = 0;
    while (!rx_avail && n < 800) begin step(1); n++; end
    chk("rx_latency_ok", (n >= 600 && n <= 620), 1'b1);
    chk("loop_rx_d", rx_d, 8'hA5);
    rx_rd = 1'b1; step(1); rx_rd = 1'b0;
    chk("rx_rd_clears", rx_avail, 1'b0);
    step(100);
    loop = 1'b0;
    step(64);

    // Framing error: byte discarded
    send_frame(8'h12, 1'b0);
    chk("ferr_no_avail", rx_avail, 1'b0);
    chk("ferr_rx_d_kept", rx_d, 8'hA5);

    // Short low glitch rejected
    rxd_drv = 1'b0; step(8); rxd_drv = 1'b1;
    step(200);
    chk("glitch_no_avail", rx_avail, 1'b0);

    // Good frame, then overrun with second frame
    send_frame(8'h5A, 1'b1);
    chk("rx5a_avail", rx_avail, 1'b1);
    chk("rx5a_data", rx_d, 8'h5A);
    send_frame(8'hC3, 1'b1);
    chk("overrun_avail", rx_avail, 1'b1);
    chk("overrun_data", rx_d, 8'hC3);

    // Asynchronous reset in the middle of a transmission
    write_tx(8'h00);
    wait_txd_low(n);
    step(200);
    write_tx(8'hFF);
    chk("pre_rst_txd_low", txd, 1'b0);
    chk("pre_rst_buf_full", tx_buf_empty, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1'b1);
    chk("async_rst_buf_empty", tx_buf_empty, 1'b1);
    chk("async_rst_rx_avail", rx_avail, 1'b0);
    chk("async_rst_rx_d", rx_d, 8'h00);
    chk("async_rst_baud_ref", baud_ref, 1'b0);
    step(2);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 800; i++) begin step(1); if (txd == 1'b0) lows++; end
    chk("post_rst_silent", lows, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
